// File: rtl/seq_exec_engine.sv
// seq_exec_engine: queued PUSH/ADD/MULT/SEND executor over a small register file.
// MULT runs a DATA_W-cycle shift-add; SEND holds its result until downstream accepts it.
module seq_exec_engine #(
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int SAT         = 0,
    localparam int RA_W       = $clog2(NUM_REGS),
    localparam int INST_W     = 2 + 3 * RA_W,
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_inst_vld,
    input  logic [INST_W-1:0] i_inst_wd,
    output logic              o_inst_rdy,
    output logic              o_send_vld,
    output logic [DATA_W-1:0] o_send_data,
    input  logic              i_send_rdy,
    output logic              o_exec_vld,
    output logic [INST_W-1:0] o_exec_wd,
    output logic              o_busy,
    output logic              o_ovf,
    input  logic              i_ovf_clr,
    output logic [CNT_W-1:0]  o_fifo_cnt
);

    localparam int IMM_W  = 2 * RA_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int MCNT_W = $clog2(DATA_W);
    localparam int EXT_W  = (IMM_W > DATA_W) ? IMM_W : DATA_W;

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_MULT = 2'b10;
    localparam logic [1:0] OP_SEND = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_MUL, ST_SEND} state_t;

    logic [INST_W-1:0]   r_fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [CNT_W-1:0]    r_fifoCnt;

    state_t              r_state;
    logic [INST_W-1:0]   r_ir;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [2*DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0]   r_mplier;
    logic [2*DATA_W-1:0] r_acc;
    logic [MCNT_W-1:0]   r_cnt;
    logic                r_sendVld;
    logic [DATA_W-1:0]   r_sendData;
    logic                r_execVld;
    logic [INST_W-1:0]   r_execWd;
    logic                r_ovf;

    logic                w_push;
    logic                w_pop;
    logic [1:0]          w_op;
    logic [RA_W-1:0]     w_ra;
    logic [RA_W-1:0]     w_rb;
    logic [RA_W-1:0]     w_rc;
    logic [IMM_W-1:0]    w_imm;
    logic [EXT_W-1:0]    w_immExt;
    logic [DATA_W-1:0]   w_opA;
    logic [DATA_W-1:0]   w_opB;
    logic [DATA_W:0]     w_sum;
    logic                w_addOvf;
    logic [DATA_W-1:0]   w_addRes;
    logic [2*DATA_W-1:0] w_accNext;
    logic                w_mulOvf;
    logic [DATA_W-1:0]   w_mulRes;

    assign o_inst_rdy  = (r_fifoCnt != CNT_W'(FIFO_DEPTH));
    assign w_push      = i_inst_vld && o_inst_rdy;
    assign w_pop       = (r_state == ST_IDLE) && (r_fifoCnt != '0);
    assign o_fifo_cnt  = r_fifoCnt;
    assign o_busy      = (r_state != ST_IDLE) || (r_fifoCnt != '0);
    assign o_send_vld  = r_sendVld;
    assign o_send_data = r_sendData;
    assign o_exec_vld  = r_execVld;
    assign o_exec_wd   = r_execWd;
    assign o_ovf       = r_ovf;

    assign w_op     = r_ir[INST_W-1 -: 2];
    assign w_ra     = r_ir[3*RA_W-1 -: RA_W];
    assign w_rb     = r_ir[2*RA_W-1 -: RA_W];
    assign w_rc     = r_ir[RA_W-1:0];
    assign w_imm    = r_ir[IMM_W-1:0];
    assign w_immExt = EXT_W'(w_imm);
    assign w_opA    = r_regs[w_rb];
    assign w_opB    = r_regs[w_rc];

    // Overflow is the carry out of ADD or any nonzero upper product half of MULT.
    assign w_sum     = {1'b0, w_opA} + {1'b0, w_opB};
    assign w_addOvf  = w_sum[DATA_W];
    assign w_addRes  = (SAT != 0 && w_addOvf) ? '1 : w_sum[DATA_W-1:0];
    assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mulOvf  = |w_accNext[2*DATA_W-1:DATA_W];
    assign w_mulRes  = (SAT != 0 && w_mulOvf) ? '1 : w_accNext[DATA_W-1:0];

    always_ff @(posedge i_clk) begin
        if (w_push) r_fifoMem[r_wrPtr] <= i_inst_wd;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_fifoCnt <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fifoCnt <= r_fifoCnt + 1'b1;
                2'b01:   r_fifoCnt <= r_fifoCnt - 1'b1;
                default: r_fifoCnt <= r_fifoCnt;
            endcase
        end
    end

    // Overflow set is assigned after the clear so a coincident overflow keeps the flag high.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= ST_IDLE;
            r_ir       <= '0;
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_sendVld  <= 1'b0;
            r_sendData <= '0;
            r_execVld  <= 1'b0;
            r_execWd   <= '0;
            r_ovf      <= 1'b0;
        end else begin
            r_execVld <= 1'b0;
            if (i_ovf_clr) r_ovf <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_ir    <= r_fifoMem[r_rdPtr];
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    case (w_op)
                        OP_PUSH: begin
                            r_regs[w_ra] <= w_immExt[DATA_W-1:0];
                            r_execVld    <= 1'b1;
                            r_execWd     <= r_ir;
                            r_state      <= ST_IDLE;
                        end
                        OP_ADD: begin
                            r_regs[w_ra] <= w_addRes;
                            if (w_addOvf) r_ovf <= 1'b1;
                            r_execVld    <= 1'b1;
                            r_execWd     <= r_ir;
                            r_state      <= ST_IDLE;
                        end
                        OP_MULT: begin
                            r_mcand  <= {{DATA_W{1'b0}}, w_opA};
                            r_mplier <= w_opB;
                            r_acc    <= '0;
                            r_cnt    <= MCNT_W'(DATA_W - 1);
                            r_state  <= ST_MUL;
                        end
                        OP_SEND: begin
                            r_sendData <= r_regs[w_ra];
                            r_sendVld  <= 1'b1;
                            r_state    <= ST_SEND;
                        end
                    endcase
                end
                ST_MUL: begin
                    r_acc    <= w_accNext;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    if (r_cnt == '0) begin
                        r_regs[w_ra] <= w_mulRes;
                        if (w_mulOvf) r_ovf <= 1'b1;
                        r_execVld    <= 1'b1;
                        r_execWd     <= r_ir;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_SEND: begin
                    if (i_send_rdy) begin
                        r_sendVld <= 1'b0;
                        r_execVld <= 1'b1;
                        r_execWd  <= r_ir;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_exec_engine.sv
// Directed bench for seq_exec_engine: a wrapping and a saturating default build share stimulus,
// and a 16-bit / 8-register / 8-deep build covers the parametric case.
module tb_seq_exec_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instVld;
    logic [7:0]  instWd;
    logic        sendRdy;
    logic        ovfClr;

    logic        instRdy, sendVld, execVld, busy, ovf;
    logic [7:0]  sendData, execWd;
    logic [2:0]  fifoCnt;

    logic        sInstRdy, sSendVld, sExecVld, sBusy, sOvf;
    logic [7:0]  sSendData, sExecWd;
    logic [2:0]  sFifoCnt;

    logic        wInstVld;
    logic [10:0] wInstWd;
    logic        wInstRdy, wSendVld, wExecVld, wBusy, wOvf;
    logic [15:0] wSendData;
    logic [10:0] wExecWd;
    logic [3:0]  wFifoCnt;

    int          nChecks = 0;
    int          nPassed = 0;
    int          cycle = 0;
    logic [7:0]  logWd[$];
    int          logCyc[$];
    logic [10:0] wLogWd[$];
    int          wLogCyc[$];

    seq_exec_engine #(.DATA_W(8), .NUM_REGS(4), .FIFO_DEPTH(4), .SAT(0)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_inst_vld(instVld), .i_inst_wd(instWd),
        .o_inst_rdy(instRdy), .o_send_vld(sendVld), .o_send_data(sendData),
        .i_send_rdy(sendRdy), .o_exec_vld(execVld), .o_exec_wd(execWd), .o_busy(busy),
        .o_ovf(ovf), .i_ovf_clr(ovfClr), .o_fifo_cnt(fifoCnt)
    );

    seq_exec_engine #(.DATA_W(8), .NUM_REGS(4), .FIFO_DEPTH(4), .SAT(1)) dutSat (
        .i_clk(clk), .i_rst_n(rst_n), .i_inst_vld(instVld), .i_inst_wd(instWd),
        .o_inst_rdy(sInstRdy), .o_send_vld(sSendVld), .o_send_data(sSendData),
        .i_send_rdy(sendRdy), .o_exec_vld(sExecVld), .o_exec_wd(sExecWd), .o_busy(sBusy),
        .o_ovf(sOvf), .i_ovf_clr(ovfClr), .o_fifo_cnt(sFifoCnt)
    );

    seq_exec_engine #(.DATA_W(16), .NUM_REGS(8), .FIFO_DEPTH(8), .SAT(0)) dutWide (
        .i_clk(clk), .i_rst_n(rst_n), .i_inst_vld(wInstVld), .i_inst_wd(wInstWd),
        .o_inst_rdy(wInstRdy), .o_send_vld(wSendVld), .o_send_data(wSendData),
        .i_send_rdy(sendRdy), .o_exec_vld(wExecVld), .o_exec_wd(wExecWd), .o_busy(wBusy),
        .o_ovf(wOvf), .i_ovf_clr(ovfClr), .o_fifo_cnt(wFifoCnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Every retirement is logged with its cycle number so ordering and latency can be checked later.
    always @(negedge clk) begin
        if (execVld) begin
            logWd.push_back(execWd);
            logCyc.push_back(cycle);
        end
        if (wExecVld) begin
            wLogWd.push_back(wExecWd);
            wLogCyc.push_back(cycle);
        end
    end

    function automatic logic [7:0] pushI(input logic [1:0] ra, input logic [3:0] imm);
        return {2'b00, ra, imm};
    endfunction
    function automatic logic [7:0] addI(input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rc);
        return {2'b01, ra, rb, rc};
    endfunction
    function automatic logic [7:0] mulI(input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] rc);
        return {2'b10, ra, rb, rc};
    endfunction
    function automatic logic [7:0] sendI(input logic [1:0] ra);
        return {2'b11, ra, 4'b0000};
    endfunction

    task automatic applyStimulus(input logic [7:0] wd);
        int t;
        @(negedge clk);
        instVld = 1'b1;
        instWd  = wd;
        t = 0;
        while (!instRdy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!instRdy) begin
            nChecks++;
            $display("[TB] FAIL enqueue_timeout wd=%h inst_rdy=%b required 1", wd, instRdy);
            instVld = 1'b0;
        end else begin
            @(posedge clk);
            #1 instVld = 1'b0;
        end
    endtask

    task automatic applyWide(input logic [10:0] wd);
        @(negedge clk);
        wInstVld = 1'b1;
        wInstWd  = wd;
        @(posedge clk);
        #1 wInstVld = 1'b0;
    endtask

    task automatic waitSendVld(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (sendVld) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitIdle(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 1000; t++) begin
            @(negedge clk);
            if (!busy && !sBusy && !wBusy) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nChecks++; if (instRdy !== 1'b1) $display("[TB] FAIL reset_inst_rdy got %b want 1", instRdy); else nPassed++;
        nChecks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy got %b want 0", busy); else nPassed++;
        nChecks++; if (sendVld !== 1'b0 || sendData !== 8'h00) $display("[TB] FAIL reset_send got vld=%b data=%h want 0/00", sendVld, sendData); else nPassed++;
        nChecks++; if (execVld !== 1'b0 || execWd !== 8'h00) $display("[TB] FAIL reset_exec got vld=%b wd=%h want 0/00", execVld, execWd); else nPassed++;
        nChecks++; if (fifoCnt !== 3'd0) $display("[TB] FAIL reset_fifo_cnt got %0d want 0", fifoCnt); else nPassed++;
        nChecks++; if (ovf !== 1'b0 || sOvf !== 1'b0) $display("[TB] FAIL reset_ovf got %b/%b want 0/0", ovf, sOvf); else nPassed++;
        nChecks++; if (wInstRdy !== 1'b1 || wBusy !== 1'b0) $display("[TB] FAIL reset_wide got rdy=%b busy=%b want 1/0", wInstRdy, wBusy); else nPassed++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_multiply;
        bit ok;
        logWd.delete();
        logCyc.delete();
        sendRdy = 1'b1;
        applyStimulus(pushI(2'd0, 4'd8));
        applyStimulus(pushI(2'd1, 4'd8));
        applyStimulus(mulI(2'd2, 2'd0, 2'd1));
        applyStimulus(sendI(2'd2));
        waitSendVld(ok);
        nChecks++; if (!ok || sendData !== 8'h40) $display("[TB] FAIL mult_send got vld=%b data=%h want 1/40", ok, sendData); else nPassed++;
        nChecks++; if (!ok || sSendData !== 8'h40) $display("[TB] FAIL mult_send_sat got %h want 40", sSendData); else nPassed++;
        waitIdle(ok);
        nChecks++; if (!ok || logWd.size() != 4 || logWd[2] !== mulI(2'd2, 2'd0, 2'd1))
            $display("[TB] FAIL mult_retire_log got n=%0d idle=%b want 4 entries, MULT third", logWd.size(), ok); else nPassed++;
        nChecks++; if (logCyc.size() != 4 || logCyc[2] - logCyc[1] != 10)
            $display("[TB] FAIL mult_latency got %0d cycles want 10", (logCyc.size() == 4) ? logCyc[2] - logCyc[1] : -1); else nPassed++;
        nChecks++; if (logCyc.size() != 4 || logCyc[3] - logCyc[2] != 3)
            $display("[TB] FAIL send_latency got %0d cycles want 3", (logCyc.size() == 4) ? logCyc[3] - logCyc[2] : -1); else nPassed++;
        nChecks++; if (ovf !== 1'b0 || sOvf !== 1'b0) $display("[TB] FAIL mult_ovf got %b/%b want 0/0", ovf, sOvf); else nPassed++;
    endtask

    task automatic test_overflow;
        bit ok;
        applyStimulus(pushI(2'd0, 4'd15));
        applyStimulus(mulI(2'd1, 2'd0, 2'd0));
        applyStimulus(mulI(2'd2, 2'd1, 2'd1));
        applyStimulus(sendI(2'd2));
        waitSendVld(ok);
        nChecks++; if (!ok || sendData !== 8'hC1) $display("[TB] FAIL ovf_wrap_data got %h want C1", sendData); else nPassed++;
        nChecks++; if (!ok || sSendData !== 8'hFF) $display("[TB] FAIL ovf_sat_data got %h want FF", sSendData); else nPassed++;
        waitIdle(ok);
        nChecks++; if (!ok || ovf !== 1'b1 || sOvf !== 1'b1) $display("[TB] FAIL ovf_set got %b/%b want 1/1", ovf, sOvf); else nPassed++;
        ovfClr = 1'b1;
        @(negedge clk);
        ovfClr = 1'b0;
        nChecks++; if (ovf !== 1'b0 || sOvf !== 1'b0) $display("[TB] FAIL ovf_clear got %b/%b want 0/0", ovf, sOvf); else nPassed++;
    endtask

    task automatic test_add_alias;
        bit ok;
        int t;
        applyStimulus(pushI(2'd3, 4'd9));
        applyStimulus(addI(2'd3, 2'd3, 2'd3));
        applyStimulus(sendI(2'd3));
        waitSendVld(ok);
        nChecks++; if (!ok || sendData !== 8'h12 || sSendData !== 8'h12) $display("[TB] FAIL add_alias got %h/%h want 12/12", sendData, sSendData); else nPassed++;
        waitIdle(ok);
        // Build R3 = 0xFF without overflow: 15*15 = 225, +15 = 240, +15 = 255.
        applyStimulus(pushI(2'd0, 4'd15));
        applyStimulus(mulI(2'd1, 2'd0, 2'd0));
        applyStimulus(addI(2'd1, 2'd1, 2'd0));
        applyStimulus(addI(2'd3, 2'd1, 2'd0));
        applyStimulus(sendI(2'd3));
        waitSendVld(ok);
        nChecks++; if (!ok || sendData !== 8'hFF || sSendData !== 8'hFF) $display("[TB] FAIL add_build_ff got %h/%h want FF/FF", sendData, sSendData); else nPassed++;
        waitIdle(ok);
        nChecks++; if (!ok || ovf !== 1'b0) $display("[TB] FAIL add_no_ovf got %b want 0", ovf); else nPassed++;
        ovfClr = 1'b1;
        applyStimulus(addI(2'd3, 2'd3, 2'd3));
        t = 0;
        while (!execVld && t < 50) begin
            @(negedge clk);
            t++;
        end
        nChecks++; if (!execVld || ovf !== 1'b1 || sOvf !== 1'b1) $display("[TB] FAIL ovf_beats_clr got exec=%b ovf=%b/%b want 1/1/1", execVld, ovf, sOvf); else nPassed++;
        @(negedge clk);
        nChecks++; if (ovf !== 1'b0 || sOvf !== 1'b0) $display("[TB] FAIL ovf_clr_after got %b/%b want 0/0", ovf, sOvf); else nPassed++;
        ovfClr = 1'b0;
        applyStimulus(sendI(2'd3));
        waitSendVld(ok);
        nChecks++; if (!ok || sendData !== 8'hFE) $display("[TB] FAIL add_wrap_ff got %h want FE", sendData); else nPassed++;
        nChecks++; if (!ok || sSendData !== 8'hFF) $display("[TB] FAIL add_sat_ff got %h want FF", sSendData); else nPassed++;
        waitIdle(ok);
        ovfClr = 1'b1;
        @(negedge clk);
        ovfClr = 1'b0;
    endtask

    task automatic test_back_to_back;
        bit ok;
        int bad;
        logic [7:0] expSeq [6];
        expSeq = '{pushI(2'd0, 4'd5), sendI(2'd0), pushI(2'd1, 4'd1), pushI(2'd2, 4'd2),
                   addI(2'd3, 2'd1, 2'd2), sendI(2'd3)};
        logWd.delete();
        logCyc.delete();
        sendRdy = 1'b0;
        applyStimulus(expSeq[0]);
        applyStimulus(expSeq[1]);
        waitSendVld(ok);
        nChecks++; if (!ok || sendData !== 8'h05) $display("[TB] FAIL bp_send_data got %h want 05", sendData); else nPassed++;
        for (int i = 2; i < 6; i++) applyStimulus(expSeq[i]);
        @(negedge clk);
        nChecks++; if (fifoCnt !== 3'd4 || instRdy !== 1'b0) $display("[TB] FAIL bp_full got cnt=%0d rdy=%b want 4/0", fifoCnt, instRdy); else nPassed++;
        instVld = 1'b1;
        instWd  = pushI(2'd0, 4'd15);
        repeat (3) @(negedge clk);
        instVld = 1'b0;
        nChecks++; if (fifoCnt !== 3'd4) $display("[TB] FAIL bp_no_write_full got %0d want 4", fifoCnt); else nPassed++;
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (sendVld !== 1'b1 || sendData !== 8'h05 || execVld !== 1'b0) bad++;
        end
        nChecks++; if (bad != 0) $display("[TB] FAIL bp_hold_stable got %0d bad cycles want 0", bad); else nPassed++;
        sendRdy = 1'b1;
        @(negedge clk);
        nChecks++; if (execVld !== 1'b1 || execWd !== sendI(2'd0) || sendVld !== 1'b0)
            $display("[TB] FAIL bp_release got exec=%b wd=%h svld=%b want 1/%h/0", execVld, execWd, sendVld, sendI(2'd0)); else nPassed++;
        nChecks++; if (instRdy !== 1'b0) $display("[TB] FAIL bp_rdy_before_pop got %b want 0", instRdy); else nPassed++;
        @(negedge clk);
        nChecks++; if (instRdy !== 1'b1 || fifoCnt !== 3'd3) $display("[TB] FAIL bp_rdy_after_pop got rdy=%b cnt=%0d want 1/3", instRdy, fifoCnt); else nPassed++;
        waitIdle(ok);
        bad = 0;
        for (int i = 0; i < 6; i++) if (i < logWd.size() && logWd[i] !== expSeq[i]) bad++;
        nChecks++; if (!ok || logWd.size() != 6 || bad != 0) $display("[TB] FAIL bp_exec_order got n=%0d mismatches=%0d want 6/0", logWd.size(), bad); else nPassed++;
    endtask

    task automatic test_reset_mid_mult;
        bit ok;
        sendRdy = 1'b1;
        applyStimulus(pushI(2'd0, 4'd3));
        applyStimulus(pushI(2'd2, 4'd9));
        waitIdle(ok);
        logWd.delete();
        logCyc.delete();
        applyStimulus(mulI(2'd2, 2'd0, 2'd0));
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        nChecks++; if (busy !== 1'b0 || fifoCnt !== 3'd0 || instRdy !== 1'b1)
            $display("[TB] FAIL rstmul_ctrl got busy=%b cnt=%0d rdy=%b want 0/0/1", busy, fifoCnt, instRdy); else nPassed++;
        nChecks++; if (execVld !== 1'b0 || execWd !== 8'h00 || sendVld !== 1'b0 || ovf !== 1'b0)
            $display("[TB] FAIL rstmul_outs got exec=%b wd=%h svld=%b ovf=%b want 0/00/0/0", execVld, execWd, sendVld, ovf); else nPassed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        nChecks++; if (logWd.size() != 0) $display("[TB] FAIL rstmul_no_exec got %0d retirements want 0", logWd.size()); else nPassed++;
        applyStimulus(sendI(2'd2));
        waitSendVld(ok);
        nChecks++; if (!ok || sendData !== 8'h00) $display("[TB] FAIL rstmul_reg_cleared got %h want 00", sendData); else nPassed++;
        applyStimulus(pushI(2'd1, 4'd7));
        applyStimulus(sendI(2'd1));
        waitSendVld(ok);
        nChecks++; if (!ok || sendData !== 8'h07) $display("[TB] FAIL rstmul_push_after got %h want 07", sendData); else nPassed++;
        waitIdle(ok);
    endtask

    task automatic test_wide;
        bit ok;
        int t;
        wLogWd.delete();
        wLogCyc.delete();
        applyWide({2'b00, 3'd7, 6'd63});
        applyWide({2'b10, 3'd6, 3'd7, 3'd7});
        applyWide({2'b11, 3'd6, 6'd0});
        t = 0;
        while (!wSendVld && t < 100) begin
            @(negedge clk);
            t++;
        end
        nChecks++; if (!wSendVld || wSendData !== 16'h0F81) $display("[TB] FAIL wide_send got vld=%b data=%h want 1/0F81", wSendVld, wSendData); else nPassed++;
        waitIdle(ok);
        nChecks++; if (!ok || wLogCyc.size() != 3 || wLogCyc[1] - wLogCyc[0] != 18)
            $display("[TB] FAIL wide_mult_latency got n=%0d diff=%0d want 3/18", wLogCyc.size(), (wLogCyc.size() == 3) ? wLogCyc[1] - wLogCyc[0] : -1); else nPassed++;
        nChecks++; if (wOvf !== 1'b0 || wFifoCnt !== 4'd0) $display("[TB] FAIL wide_final got ovf=%b cnt=%0d want 0/0", wOvf, wFifoCnt); else nPassed++;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog time limit reached, simulation still running, required completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        instVld  = 1'b0;
        instWd   = '0;
        wInstVld = 1'b0;
        wInstWd  = '0;
        sendRdy  = 1'b1;
        ovfClr   = 1'b0;
        test_reset;
        test_multiply;
        test_overflow;
        test_add_alias;
        test_back_to_back;
        test_reset_mid_mult;
        test_wide;
        $display("[TB] %0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
